cell_window_gen: RTL
====================

Name: cell_window_gen

Overview:
Upstream stage of the cell processor. It accepts a raster-order pixel stream, one 24-bit pixel per transfer, and buffers two image lines in internal line buffers. It emits one complete 3x3 cell (cell_t layout) for every pixel position whose full neighbourhood lies inside the frame. The output image is (IMAGE_WIDTH-2) x (IMAGE_HEIGHT-2) cells, matching txImage_t dimensions; the cell processor consumes it directly.

Parameters:
CHANNEL_WIDTH, 8, bits per colour channel; pixel = 3*CHANNEL_WIDTH, {red,green,blue}, red in MSBs
IMAGE_WIDTH, 640, pixels per line (minimum 3)
IMAGE_HEIGHT, 480, lines per frame (minimum 3)
CELL_N, 3, window size; fixed at 3, any other value is a compile-time error

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
pix_valid  in  1  pixel input valid
pix_ready  out  1  pixel input ready
pix_data  in  24  pixel {red,green,blue}
pix_sof  in  1  start-of-frame; qualifies the pixel being transferred
cell_valid  out  1  cell output valid
cell_ready  in  1  cell output ready
cell_data  out  216  3x3 cell; element [r][c] at bits [(r*3+c)*24 +: 24]
cell_x  out  $clog2(IMAGE_WIDTH)  column of the cell centre pixel in the input image
cell_y  out  $clog2(IMAGE_HEIGHT)  row of the cell centre pixel in the input image
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low.
- Reset (reset_n=0 at a clock edge):
  - cell_valid, cell_data, cell_x, cell_y, frame_done = 0.
  - col/row counters = 0.
  - pix_ready = 0 while reset_n is low.
  - Line-buffer contents are not cleared; they need no reset.
- Transfer rules:
  - Input accept = pix_valid & pix_ready. Output transfer = cell_valid & cell_ready.
  - pix_ready = reset_n & (~cell_valid | cell_ready). This is combinational, giving a single output register with pass-through backpressure.
  - cell_data, cell_x and cell_y are held stable while cell_valid=1 and cell_ready=0.
- Position counters:
  - col runs 0..IMAGE_WIDTH-1 and row runs 0..IMAGE_HEIGHT-1. They advance only on accept.
  - col wraps to 0 and row increments. At (W-1, H-1) both wrap to 0.
  - An accepted pixel with pix_sof=1 is treated as position (0,0) regardless of the counters. It is a mid-frame resync; the partial frame is discarded with no frame_done.
- Line buffers:
  - Two IMAGE_WIDTH-deep buffers, one read and one write per accept at address col.
  - lb1 holds row-1 and lb0 holds row-2.
  - On accept: lb0[col] <= lb1[col], lb1[col] <= pix_data.
- Window:
  - A 3x3 shift register. On accept, columns shift left and the new right column is {lb0[col], lb1[col], pix_data} for rows 0..2.
  - r=0 is the top (oldest) line and c=0 is the leftmost (oldest) column. [2][2] is the just-accepted pixel and [1][1] is the centre.
- Cell emission:
  - On accept with row>=2 and col>=2 (positions after the sof override), the next cycle has cell_valid=1.
  - cell_data is the updated window, cell_x = col-1, cell_y = row-1.
  - If no new cell is produced and the output transfers, cell_valid drops to 0.
  - Latency: exactly 1 cycle from the accepting edge.
- Boundaries:
  - Windows that straddle a row wrap or frame boundary (col<2 or row<2) are never emitted.
  - The first two lines of a new frame emit nothing, so stale line-buffer data never reaches the output.
- frame_done: 1-cycle pulse on the cycle after the pixel at (W-1, H-1) is accepted. It coincides with cell_valid for the final cell.
- Simultaneous events: an output transfer and a new accept on the same edge load the new cell with no bubble. Sustained throughput is 1 cell per cycle.

Test Plan:
All tests use W=5, H=4 and pixel (r,c) = {red=r, green=c, blue=16*r+c}.
1. One frame, pix_valid=1, cell_ready=1:
   - Exactly 6 cells.
   - First cell_valid 1 cycle after accepting (2,2): cell_x=1, cell_y=1, element[0][0].blue=0x00, [1][1].blue=0x11, [2][2].blue=0x22.
   - Last cell: cell_x=3, cell_y=2, [2][2].blue=0x34.
   - frame_done coincides with the last cell.
2. Hold cell_ready=0 for 5 cycles at the first cell:
   - pix_ready=0, and cell_data/cell_x/cell_y are held stable.
   - After release the sequence is identical to test 1 and no pixel is lost.
3. Assert reset_n=0 for 2 cycles after 8 accepted pixels:
   - All outputs are 0 and pix_ready=0 during reset.
   - A following full frame reproduces test 1 exactly.
4. Pulse pix_sof on the 7th pixel of a frame:
   - That pixel is treated as (0,0).
   - No cell appears until 12 pixels later; no frame_done is produced for the aborted frame.
5. pix_valid toggled every other cycle, with random cell_ready stalls: the cell sequence and contents are identical to test 1.
6. Two back-to-back frames with no idle cycle:
   - 12 cells and two frame_done pulses.
   - The first frame-2 cell is (1,1) with [0][0].blue=0x00 and contains no frame-1 data.

Source files
------------

// File: rtl/cell_window_gen.sv
// cell_window_gen: turns a raster-order pixel stream into 3x3 cells.
// Two line buffers hold the previous two lines, and a 3x3 shift register
// forms the window. One output register gives pass-through backpressure.
// Only windows that lie fully inside the frame are emitted.
module cell_window_gen #(
   parameter int CHANNEL_WIDTH = 8,
   parameter int IMAGE_WIDTH   = 640,
   parameter int IMAGE_HEIGHT  = 480,
   parameter int CELL_N        = 3
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            pix_valid,
   output logic                            pix_ready,
   input  logic [3*CHANNEL_WIDTH-1:0]      pix_data,
   input  logic                            pix_sof,
   output logic                            cell_valid,
   input  logic                            cell_ready,
   output logic [27*CHANNEL_WIDTH-1:0]     cell_data,
   output logic [$clog2(IMAGE_WIDTH)-1:0]  cell_x,
   output logic [$clog2(IMAGE_HEIGHT)-1:0] cell_y,
   output logic                            frame_done
);

   localparam int PIX_W = 3 * CHANNEL_WIDTH;
   localparam int COL_W = $clog2(IMAGE_WIDTH);
   localparam int ROW_W = $clog2(IMAGE_HEIGHT);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT - 1);
   localparam logic [COL_W-1:0] EDGE_COL = COL_W'(2);
   localparam logic [ROW_W-1:0] EDGE_ROW = ROW_W'(2);

   if (CELL_N != 3) begin : gCellNCheck
      $error("cell_window_gen: CELL_N must be 3");
   end
   if (IMAGE_WIDTH < 3 || IMAGE_HEIGHT < 3) begin : gSizeCheck
      $error("cell_window_gen: image must be at least 3x3");
   end

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] colEff;
   logic [ROW_W-1:0] rowEff;
   logic             accept;
   logic             emit;
   logic             isLast;
   logic [PIX_W-1:0] lineBuf0 [IMAGE_WIDTH];
   logic [PIX_W-1:0] lineBuf1 [IMAGE_WIDTH];
   logic [PIX_W-1:0] lb0Rd;
   logic [PIX_W-1:0] lb1Rd;
   // Packed as [row][col][pixel] so the flattened layout is (r*3+c)*PIX_W.
   logic [2:0][2:0][PIX_W-1:0] window;
   logic [2:0][2:0][PIX_W-1:0] windowNext;

   assign pix_ready = reset_n & (~cell_valid | cell_ready);
   assign accept    = pix_valid & pix_ready;
   // A start-of-frame pixel overrides the counters and is taken as (0,0).
   assign colEff    = pix_sof ? '0 : col;
   assign rowEff    = pix_sof ? '0 : row;
   assign lb0Rd     = lineBuf0[colEff];
   assign lb1Rd     = lineBuf1[colEff];
   assign emit      = accept && (rowEff >= EDGE_ROW) && (colEff >= EDGE_COL);
   assign isLast    = (colEff == LAST_COL) && (rowEff == LAST_ROW);

   // Shift the window left and insert the new right column.
   always_comb begin
      windowNext = window;
      for (int unsigned r = 0; r < 3; r++) begin
         windowNext[r][0] = window[r][1];
         windowNext[r][1] = window[r][2];
      end
      windowNext[0][2] = lb0Rd;
      windowNext[1][2] = lb1Rd;
      windowNext[2][2] = pix_data;
   end

   // Line buffers: age the stored column by one line on every accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         lineBuf0[colEff] <= lb1Rd;
         lineBuf1[colEff] <= pix_data;
      end
   end

   // Window register; contents are only meaningful once two lines are in.
   always_ff @(posedge clk) begin
      if (accept) begin
         window <= windowNext;
      end
   end

   // Position counters, output register and frame-done pulse.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         col        <= '0;
         row        <= '0;
         cell_valid <= 1'b0;
         cell_data  <= '0;
         cell_x     <= '0;
         cell_y     <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= accept && isLast;
         if (accept) begin
            if (colEff == LAST_COL) begin
               col <= '0;
               row <= (rowEff == LAST_ROW) ? '0 : rowEff + 1'b1;
            end else begin
               col <= colEff + 1'b1;
               row <= rowEff;
            end
         end
         if (emit) begin
            cell_valid <= 1'b1;
            cell_data  <= windowNext;
            cell_x     <= colEff - 1'b1;
            cell_y     <= rowEff - 1'b1;
         end else if (cell_ready) begin
            cell_valid <= 1'b0;
         end
      end
   end

endmodule
